// File: rtl/lc3b_types.sv
// Shared LC-3b data types plus the cache controller state encoding and helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_8word;
    typedef logic [1:0]   lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } cache_state_t;

    // Byte offset within a 16-byte line.
    localparam int       OFFSET_W = 4;
    localparam lc3b_word CNT_MAX  = 16'hFFFF;

    // Event counters stick at all-ones instead of wrapping.
    function automatic lc3b_word sat_inc(input lc3b_word v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set tag, valid, dirty and 128-bit line storage.
// Latency: combinational read of the indexed set; writes land on the next rising edge.
// Backpressure: none; the controller owns sequencing, fill takes priority over word write.
module cache_way_array
    import lc3b_types::*;
#(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 16 - OFFSET_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  lc3b_8word        fill_line,
    input  logic             word_en,
    input  logic [2:0]       word_sel,
    input  lc3b_mem_wmask    byte_en,
    input  lc3b_word         wdata,
    input  logic             clean_en,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic             rd_dirty,
    output lc3b_8word        rd_line
);

    logic [TAG_W-1:0] tag_mem  [SETS];
    lc3b_8word        data_mem [SETS];
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[index]  <= fill_tag;
            data_mem[index] <= fill_line;
        end else if (word_en) begin
            if (byte_en[0]) data_mem[index][{word_sel, 4'h0} +: 8] <= wdata[7:0];
            if (byte_en[1]) data_mem[index][{word_sel, 4'h8} +: 8] <= wdata[15:8];
        end
    end

    // Status bits: a fill makes the line clean and valid, a non-empty write dirties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_en && (byte_en != 2'b00)) begin
            dirty_q[index] <= 1'b1;
        end else if (clean_en) begin
            dirty_q[index] <= 1'b0;
        end
    end

    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_line  = data_mem[index];

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with tree pseudo-LRU replacement and event counters.
// Latency: hit responds one cycle after the request is seen; miss adds optional writeback plus fill.
// Backpressure: CPU holds mem_read/mem_write until mem_resp; memory side holds pmem_read/write until pmem_resp.
module cache_nway
    import lc3b_types::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  lc3b_word      mem_address,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_wdata,
    output lc3b_word      mem_rdata,
    output logic          mem_resp,
    output lc3b_word      pmem_address,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_8word     pmem_wdata,
    input  lc3b_8word     pmem_rdata,
    input  logic          pmem_resp,
    output lc3b_word      hit_count,
    output lc3b_word      miss_count,
    output lc3b_word      wb_count
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 16 - OFFSET_W - IDX_W;
    localparam int LVL    = $clog2(WAYS);
    localparam int WAY_W  = (WAYS > 1) ? LVL : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       req_word;
    logic             addr_unused;

    assign req_idx     = mem_address[OFFSET_W +: IDX_W];
    assign req_tag     = mem_address[15 -: TAG_W];
    assign req_word    = mem_address[3:1];
    assign addr_unused = mem_address[0];

    logic [TAG_W-1:0] way_tag [WAYS];
    lc3b_8word        way_line [WAYS];
    logic [WAYS-1:0]  way_valid, way_dirty, way_hit;
    logic [WAYS-1:0]  way_fill, way_word, way_clean;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_array #(
            .SETS  (SETS),
            .IDX_W (IDX_W),
            .TAG_W (TAG_W)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .index     (req_idx),
            .fill_en   (way_fill[w] & ~rst),
            .fill_tag  (req_tag),
            .fill_line (pmem_rdata),
            .word_en   (way_word[w] & ~rst),
            .word_sel  (req_word),
            .byte_en   (mem_byte_enable),
            .wdata     (mem_wdata),
            .clean_en  (way_clean[w] & ~rst),
            .rd_tag    (way_tag[w]),
            .rd_valid  (way_valid[w]),
            .rd_dirty  (way_dirty[w]),
            .rd_line   (way_line[w])
        );
        assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
    end

    cache_state_t     state, state_nxt;
    logic             hit;
    logic             refill_q;
    logic [WAY_W-1:0] hit_way, free_way, plru_way, victim, victim_q;
    logic             any_free;
    logic [PLRU_W-1:0] plru_q [SETS];
    logic [PLRU_W-1:0] plru_cur, plru_upd;

    assign hit      = |way_hit;
    assign plru_cur = plru_q[req_idx];
    assign victim   = any_free ? free_way : plru_way;

    // Encode which way matched the request tag.
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_way = WAY_W'(w);
        end
    end

    // Lowest-numbered invalid way, scanned downward so the lowest wins.
    always_comb begin
        free_way = '0;
        any_free = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                free_way = WAY_W'(w);
                any_free = 1'b1;
            end
        end
    end

    // Walk the pLRU tree from the root: each node bit says which half to evict from (1 = upper).
    always_comb begin : plru_walk
        int node;
        node = 1;
        for (int l = 0; l < LVL; l++) begin
            node = 2 * node + int'((plru_cur >> (node - 1)) & PLRU_W'(1));
        end
        plru_way = WAY_W'(node - WAYS);
    end

    // Point every node on the accessed way's path at the opposite half.
    always_comb begin : plru_touch
        int node;
        int dir;
        plru_upd = plru_cur;
        node     = 1;
        for (int l = 0; l < LVL; l++) begin
            dir = (int'(hit_way) >> (LVL - 1 - l)) & 1;
            if (dir != 0) plru_upd = plru_upd & ~(PLRU_W'(1) << (node - 1));
            else          plru_upd = plru_upd |  (PLRU_W'(1) << (node - 1));
            node = 2 * node + dir;
        end
    end

    // Replacement state per set, refreshed on every hit including the post-fill compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (state == COMPARE && hit) begin
            plru_q[req_idx] <= plru_upd;
        end
    end

    // Controller state, latched miss victim, and a flag marking the compare that follows a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            victim_q <= '0;
            refill_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            refill_q <= (state == FILL) && pmem_resp;
            if (state == COMPARE && !hit) victim_q <= victim;
        end
    end

    // Next-state and per-state strobes; pmem_resp only matters while a transfer is outstanding.
    always_comb begin
        state_nxt  = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        way_fill   = '0;
        way_word   = '0;
        way_clean  = '0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) state_nxt = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    mem_resp  = 1'b1;
                    state_nxt = IDLE;
                    if (mem_write) way_word[hit_way] = 1'b1;
                end else if (way_valid[victim] && way_dirty[victim]) begin
                    state_nxt = WRITEBACK;
                end else begin
                    state_nxt = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    way_clean[victim_q] = 1'b1;
                    state_nxt           = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    way_fill[victim_q] = 1'b1;
                    state_nxt          = COMPARE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating event counters; the re-compare after a fill is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == COMPARE && hit && !refill_q) hit_count  <= sat_inc(hit_count);
            if (state == FILL && pmem_resp)           miss_count <= sat_inc(miss_count);
            if (state == WRITEBACK && pmem_resp)      wb_count   <= sat_inc(wb_count);
        end
    end

    assign mem_rdata    = way_line[hit_way][{req_word, 4'h0} +: 16];
    assign pmem_address = (state == WRITEBACK) ? {way_tag[victim_q], req_idx, 4'h0}
                                               : {req_tag, req_idx, 4'h0};
    assign pmem_wdata   = way_line[victim_q];

endmodule

// File: tb/tb_cache_nway.sv
// Bench for cache_nway: directed scenarios plus a randomized scoreboard phase.
// Latency: checks hit timing in request cycles; memory model answers after three cycles.
// Backpressure: CPU requests held until mem_resp, dropped at the following edge.
module tb_cache_nway;
    import lc3b_types::*;

    logic          clk;
    logic          rst;
    lc3b_word      mem_address;
    logic          mem_read, mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_wdata, mem_rdata;
    logic          mem_resp;
    lc3b_word      pmem_address;
    logic          pmem_read, pmem_write;
    lc3b_8word     pmem_wdata, pmem_rdata;
    logic          pmem_resp;
    lc3b_word      hit_count, miss_count, wb_count;

    cache_nway #(.WAYS(2), .SETS(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .hit_count       (hit_count),
        .miss_count      (miss_count),
        .wb_count        (wb_count)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail   = 0;
    lc3b_word  exp_q [$];
    lc3b_8word mem_m [int];
    lc3b_word  shadow [int];
    bit        auto_mem = 1'b1;
    bit        late_resp = 1'b0;
    int        pmem_viol = 0;
    logic      seen_rd, seen_wr;
    lc3b_word  rd_addr, wr_addr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Backing memory contents; untouched lines follow a fixed address-derived pattern.
    function automatic lc3b_8word line_of(input int la);
        lc3b_8word l;
        if (mem_m.exists(la)) return mem_m[la];
        for (int k = 0; k < 8; k++) l[16*k +: 16] = 16'(la) ^ (16'h1111 * 16'(k + 1));
        return l;
    endfunction

    // CPU-visible line: backing memory overlaid with every write the CPU has completed.
    function automatic lc3b_8word cpu_line(input int la);
        lc3b_8word l;
        l = line_of(la);
        for (int k = 0; k < 8; k++) begin
            if (shadow.exists(la + 2*k)) l[16*k +: 16] = shadow[la + 2*k];
        end
        return l;
    endfunction

    function automatic lc3b_word cpu_word(input int a);
        lc3b_8word l;
        l = cpu_line(a & ~15);
        return l[16*((a >> 1) & 7) +: 16];
    endfunction

    // Memory responder: answers each transfer after three observed cycles.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = late_resp;
            late_resp = 1'b0;
            if (pmem_read && pmem_write) pmem_viol++;
            if (auto_mem && (pmem_read || pmem_write)) begin
                wait_cnt++;
                if (wait_cnt == 3) begin
                    wait_cnt = 0;
                    if (pmem_write) begin
                        chk("wb_line", pmem_wdata, cpu_line(int'(pmem_address)));
                        mem_m[int'(pmem_address)] = pmem_wdata;
                    end else begin
                        pmem_rdata = line_of(int'(pmem_address));
                    end
                    pmem_resp = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // One CPU transaction; reads push their expected word, compared when mem_resp arrives.
    task automatic cpu_req(input string tag, input logic rd, input logic wr, input lc3b_word addr,
                           input lc3b_word wd, input lc3b_mem_wmask be,
                           output int cyc, output lc3b_word rdat);
        lc3b_word e;
        lc3b_word w;
        mem_address = addr; mem_read = rd; mem_write = wr;
        mem_wdata = wd; mem_byte_enable = be;
        seen_rd = 1'b0; seen_wr = 1'b0; rd_addr = '0; wr_addr = '0;
        rdat = '0;
        if (!wr) exp_q.push_back(cpu_word(int'(addr)));
        cyc = 1;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (pmem_read && !seen_rd)  begin seen_rd = 1'b1; rd_addr = pmem_address; end
            if (pmem_write && !seen_wr) begin seen_wr = 1'b1; wr_addr = pmem_address; end
        end while (!mem_resp && cyc < 200);
        if (!mem_resp) begin
            chk({tag, "_timeout"}, 1'b0, 1'b1);
            if (!wr) e = exp_q.pop_front();
        end else if (!wr) begin
            rdat = mem_rdata;
            e = exp_q.pop_front();
            chk(tag, mem_rdata, e);
        end else begin
            w = cpu_word(int'(addr));
            if (be[0]) w[7:0]  = wd[7:0];
            if (be[1]) w[15:8] = wd[15:8];
            shadow[int'(addr) & ~1] = w;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        int        cyc;
        lc3b_word  rdat;
        lc3b_8word l;
        lc3b_word  pool [8];
        bit        any_resp, any_pm;
        int        n;
        pool = '{16'h1234, 16'h1A34, 16'h2234, 16'h3234, 16'h0010, 16'h4016, 16'h8FFE, 16'h1230};

        rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0;
        l = line_of(32'h1230);
        l[47:32] = 16'h5678;
        mem_m[32'h1230] = l;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_hit_count", hit_count, 16'h0);
        chk("rst_miss_count", miss_count, 16'h0);
        chk("rst_wb_count", wb_count, 16'h0);
        rst = 1'b0;

        cpu_req("cold_rdata", 1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, cyc, rdat);
        chk("cold_rdata_word2", rdat, 16'h5678);
        chk("cold_pmem_read", seen_rd, 1'b1);
        chk("cold_pmem_addr", rd_addr, 16'h1230);
        chk("cold_no_wb", seen_wr, 1'b0);
        chk("cold_miss_count", miss_count, 16'd1);
        chk("cold_hit_count", hit_count, 16'd0);

        cpu_req("hit_rdata", 1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, cyc, rdat);
        chk("hit_latency", cyc, 2);
        chk("hit_no_pmem", seen_rd | seen_wr, 1'b0);
        chk("hit_count_1", hit_count, 16'd1);

        cpu_req("wr_lo", 1'b0, 1'b1, 16'h1234, 16'hABCD, 2'b01, cyc, rdat);
        chk("wr_latency", cyc, 2);
        cpu_req("rd_after_wr", 1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, cyc, rdat);
        chk("rd_merged", rdat, 16'h56CD);
        cpu_req("wr_nomask", 1'b0, 1'b1, 16'h1234, 16'hFFFF, 2'b00, cyc, rdat);
        cpu_req("rd_nomask", 1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, cyc, rdat);
        chk("nomask_unchanged", rdat, 16'h56CD);
        cpu_req("wr_both", 1'b1, 1'b1, 16'h1236, 16'h1111, 2'b11, cyc, rdat);
        cpu_req("rd_both", 1'b1, 1'b0, 16'h1236, 16'h0, 2'b00, cyc, rdat);
        chk("both_is_write", rdat, 16'h1111);

        cpu_req("rd_1a34", 1'b1, 1'b0, 16'h1A34, 16'h0, 2'b00, cyc, rdat);
        chk("1a34_fill_addr", rd_addr, 16'h1A30);
        chk("1a34_no_wb", seen_wr, 1'b0);
        cpu_req("rd_2234", 1'b1, 1'b0, 16'h2234, 16'h0, 2'b00, cyc, rdat);
        chk("evict_wb_seen", seen_wr, 1'b1);
        chk("evict_wb_addr", wr_addr, 16'h1230);
        chk("evict_fill_addr", rd_addr, 16'h2230);
        chk("evict_wb_count", wb_count, 16'd1);
        chk("evict_miss_count", miss_count, 16'd3);

        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            cpu_req("rand_rdata", op != 1, op != 0, pool[$urandom_range(0, 7)],
                    16'($urandom), 2'($urandom_range(0, 3)), cyc, rdat);
        end

        auto_mem = 1'b0;
        mem_address = 16'h5234; mem_read = 1'b1;
        n = 0;
        while (!pmem_read && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstfill_reached", pmem_read, 1'b1);
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        chk("rstfill_pmem_read_low", pmem_read, 1'b0);
        rst = 1'b0;
        late_resp = 1'b1;
        shadow.delete();
        any_resp = 1'b0; any_pm = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_resp) any_resp = 1'b1;
            if (pmem_read || pmem_write) any_pm = 1'b1;
        end
        chk("rstfill_no_resp", any_resp, 1'b0);
        chk("rstfill_no_pmem", any_pm, 1'b0);
        chk("rstfill_miss_count", miss_count, 16'd0);
        auto_mem = 1'b1;

        cpu_req("reread_rdata", 1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, cyc, rdat);
        chk("reread_miss", seen_rd, 1'b1);
        chk("reread_addr", rd_addr, 16'h1230);
        chk("reread_miss_count", miss_count, 16'd1);
        chk("reread_hit_count", hit_count, 16'd0);

        force dut.hit_count = 16'hFFFF;
        #1;
        release dut.hit_count;
        cpu_req("sat_rdata", 1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, cyc, rdat);
        chk("sat_latency", cyc, 2);
        chk("sat_hit_count", hit_count, 16'hFFFF);

        chk("pmem_rd_wr_exclusive", pmem_viol, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/cache_nway.md
CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter SETS, default 8, sets per way; power of 2, 2..64.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_address  input  16  CPU byte address.
REQ-006 SHALL have ports mem_read and mem_write  input  1 each  CPU requests, held until mem_resp.
REQ-007 SHALL have port mem_byte_enable  input  2 (lc3b_mem_wmask)  write byte mask; bit0 = low byte.
REQ-008 SHALL have port mem_wdata  input  16  CPU write data.
REQ-009 SHALL have port mem_rdata  output  16  CPU read data.
REQ-010 SHALL have port mem_resp  output  1  one-cycle completion pulse.
REQ-011 SHALL have port pmem_address  output  16  line address, bits [3:0] always zero.
REQ-012 SHALL have ports pmem_read and pmem_write  output  1 each  memory requests, held until pmem_resp.
REQ-013 SHALL have ports pmem_wdata  output  128 (lc3b_8word)  and pmem_rdata  input  128  line data.
REQ-014 SHALL have port pmem_resp  input  1  memory completion.
REQ-015 SHALL have ports hit_count, miss_count and wb_count  output  16 each  saturating event counters.

Function
REQ-016 Address split SHALL be: offset [3:0] (word [3:1]); index [3+log2(SETS):4]; tag = remaining upper bits.
REQ-017 FSM SHALL have states IDLE, COMPARE, WRITEBACK and FILL.
REQ-018 IDLE: if mem_read or mem_write is high, go to COMPARE next cycle; otherwise stay in IDLE.
REQ-019 COMPARE, hit: assert mem_resp this cycle; update LRU; perform the write if any; go to IDLE.
REQ-020 COMPARE, miss: go to WRITEBACK if the victim is valid and dirty, otherwise go to FILL.
REQ-021 Hit latency SHALL be 1 cycle after request entry, so mem_resp is asserted in the second cycle the request is high.
REQ-022 WRITEBACK: hold pmem_write; pmem_address = {victim tag, index, 4'b0}; pmem_wdata = victim line. On pmem_resp, clear the victim's dirty bit, increment wb_count, go to FILL.
REQ-023 FILL: hold pmem_read; pmem_address = {req tag, index, 4'b0}. On pmem_resp, write pmem_rdata into the victim; set valid=1, dirty=0, tag=req tag; increment miss_count; return to COMPARE, which then hits.
REQ-024 pmem_resp SHALL be ignored in IDLE and COMPARE.
REQ-025 pmem_read and pmem_write SHALL never be asserted together.
REQ-026 Victim selection SHALL take the lowest-numbered invalid way; if all ways are valid, the tree pseudo-LRU way (WAYS-1 bits per set).
REQ-027 On every hit, the pLRU bits SHALL be updated to point away from the accessed way. With WAYS=1, way 0 SHALL always be chosen.
REQ-028 Write hit: update only the bytes enabled by mem_byte_enable in word [3:1], and set dirty. With mask 2'b00: mem_resp, no data change, dirty unchanged.
REQ-029 If mem_read and mem_write are both high, the request SHALL be treated as a write.
REQ-030 mem_rdata SHALL be the addressed word of the hit way, valid while mem_resp is high; otherwise don't-care.
REQ-031 hit_count SHALL increment on the first COMPARE of a request that hits, not on the post-fill re-compare.
REQ-032 All counters SHALL saturate at 16'hFFFF.

Reset
REQ-033 When rst is high at a clock edge: FSM to IDLE; all valid, dirty and pLRU bits to 0; counters to 0; mem_resp, pmem_read and pmem_write to 0 from the next cycle.
REQ-034 Reset during WRITEBACK or FILL SHALL abandon the transfer; a pmem_resp arriving afterwards SHALL be ignored.
REQ-035 Reset SHALL NOT be required to clear tag or data storage.

Structure
REQ-036 lc3b_word, lc3b_8word and lc3b_mem_wmask SHALL come from lc3b_types; a cache FSM state enum SHALL be added to that package.
REQ-037 SHALL instantiate WAYS copies of sub-module cache_way_array, each holding tag, valid, dirty and data per set, with byte-masked word write and full-line write.
REQ-038 pLRU, victim select, counters and FSM SHALL reside in cache_nway.

Verification (WAYS=2, SETS=8; 0x1234 -> index 3, word 2)
REQ-039 Cold read 0x1234 -> pmem_read with pmem_address 0x1230; after pmem_resp, mem_resp with mem_rdata = line word 2; miss_count=1.
REQ-040 Read 0x1234 again -> mem_resp in 2nd request cycle; no pmem activity; hit_count=1.
REQ-041 Write 0x1234, data 0xABCD, mask 01, over 0x5678 -> read returns 0x56CD.
REQ-042 Fill 0x1234 (dirty), then 0x1A34, then read 0x2234 -> pmem_write to 0x1230 with dirty line, then pmem_read 0x2230; wb_count=1.
REQ-043 rst asserted mid-FILL, then pmem_resp -> pmem_read low next cycle; no mem_resp; re-read 0x1234 misses.
REQ-044 Force hit_count to 0xFFFF, then one hit -> hit_count stays 0xFFFF.
